unidade_controle_jogo: RTL and testbench
========================================

Name: unidade_controle_jogo

Overview:
Moore FSM that sequences the memory-game datapath for one round. It:
- clears the address counter and the play register;
- waits for each edge-detected play;
- strobes the play into the register;
- checks the comparator result;
- advances the address until the last position or the first mismatch.

It sits directly upstream of the datapath, driving its control inputs (zeraC, contaC, zeraR, registraR) and consuming its status outputs (igual, fimC, jogada_feita). It adds a per-play inactivity timeout.

Parameters:
TIMEOUT, 5000, maximum consecutive cycles spent in ESPERA without a play before the round ends in timeout; 0 disables the timeout.

Ports:
clock  in  1  system clock, all state changes on the rising edge
reset  in  1  synchronous, active-high; forces INICIAL and clears the timeout counter
iniciar  in  1  level; starts a round from INICIAL or any final state
jogada_feita  in  1  one-cycle pulse from the datapath edge detector
igual  in  1  comparator result (memory data == registered play)
fimC  in  1  address counter at last position (rco)
zeraC  out  1  clear address counter
contaC  out  1  increment address counter
zeraR  out  1  clear play register
registraR  out  1  load play register
pronto  out  1  round finished (any final state)
acertou  out  1  round finished, all positions matched
errou  out  1  round finished by mismatch or timeout
timeout  out  1  round finished by timeout
db_estado  out  4  current state code, for the HEX display

Behaviour:
- All outputs are Moore: decoded from state only, no input-to-output combinational paths.
- State codes (db_estado):
  - INICIAL=0x0, PREPARA=0x1, ESPERA=0x2, REGISTRA=0x4, COMPARA=0x5, PROXIMO=0x6
  - FIM_ACERTO=0xA, FIM_ERRO=0xE, FIM_TIMEOUT=0xD
  - Any unused code → INICIAL on the next edge.
- Reset: state=INICIAL, timeout counter=0. Every output is 0, and db_estado=0x0, from the edge where reset is sampled high. Reset has priority over all inputs in every state, including mid-round.
- INICIAL: all outputs 0. iniciar=1 → PREPARA, else stay.
- PREPARA: zeraC=1, zeraR=1, held for exactly 1 cycle; unconditionally → ESPERA.
- ESPERA: all outputs 0. The timeout counter increments each cycle spent here. Evaluated in priority order:
  1. jogada_feita=1 → REGISTRA.
  2. Else if TIMEOUT≠0 and counter==TIMEOUT-1 → FIM_TIMEOUT.
  3. Else stay.
- ESPERA occupancy: with no play, at most TIMEOUT cycles. If jogada_feita arrives in the same cycle as expiry, the play wins.
- Timeout counter: held at 0 in every state other than ESPERA, so it restarts on each entry. Width is ceil(log2(TIMEOUT+1)) with a minimum of 1 bit. The counter never wraps: it is compared before incrementing.
- REGISTRA: registraR=1 for 1 cycle → COMPARA. This gives the synchronous ROM and the register one full cycle before the compare.
- COMPARA: all outputs 0.
  - igual=0 → FIM_ERRO.
  - igual=1 and fimC=1 → FIM_ACERTO.
  - igual=1 and fimC=0 → PROXIMO.
- PROXIMO: contaC=1 for 1 cycle → ESPERA. The datapath edge detector is cleared by contaC, so a switch still held down does not create a new play.
- FIM_ACERTO: pronto=1, acertou=1.
- FIM_ERRO: pronto=1, errou=1.
- FIM_TIMEOUT: pronto=1, errou=1, timeout=1.
- All final states: hold outputs until iniciar=1, then → PREPARA, which restarts the round.
- iniciar is ignored in every state except INICIAL and the final states.
- jogada_feita is ignored outside ESPERA.
- zeraC/contaC and zeraR/registraR are never asserted in the same cycle.
- Per-play latency from a jogada_feita pulse in ESPERA:
  - REGISTRA on the next edge;
  - COMPARA +1;
  - PROXIMO or final state +2;
  - back in ESPERA +3.

Test Plan:
1. reset=1 for 2 cycles with iniciar=1 → db_estado=0x0 and all outputs 0. Release reset with iniciar=1 → next cycle db_estado=0x1, zeraC=zeraR=1 for exactly 1 cycle, then 0x2.
2. Full win, TIMEOUT=20: 16 plays, each a jogada_feita pulse with igual=1, fimC=1 only on the 16th → contaC pulses exactly 15 times, registraR 16 times; db_estado sequence per play 2→4→5→6; ends at 0xA with pronto=acertou=1, errou=0.
3. Mismatch: 3rd play with igual=0 → state 0x5 then 0xE, pronto=errou=1, timeout=0, only 2 contaC pulses. Then iniciar=1 → 0x1 → 0x2.
4. Timeout, TIMEOUT=8: enter ESPERA, no play → exactly 8 cycles in 0x2, then 0xD with pronto=errou=timeout=1. Repeat with a jogada_feita pulse on the 8th cycle → 0x4, no timeout.
5. Counter restart: play at the 7th ESPERA cycle, with TIMEOUT=8 and igual=1, fimC=0 → after PROXIMO, ESPERA again tolerates a full 8 idle cycles before 0xD.
6. reset=1 asserted while in COMPARA and while in ESPERA with the counter at 5 → next cycle 0x0, all outputs 0. After restart, the timeout again takes the full 8 cycles.

Source files
------------

// File: rtl/unidade_controle_jogo.sv
// Moore controller that sequences one round of the memory game datapath.
// Ports: clock/reset, iniciar, status (jogada_feita, igual, fimC) in;
//   control (zeraC, contaC, zeraR, registraR), result flags, db_estado out.
module unidade_controle_jogo #(
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } state_t;

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST =
    (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          expira;

  assign expira = (TIMEOUT != 0) && (cnt == LAST);

  always_comb begin
    nxt = state;
    case (state)
      INICIAL:  nxt = iniciar ? PREPARA : INICIAL;
      PREPARA:  nxt = ESPERA;
      ESPERA: begin
        if (jogada_feita) nxt = REGISTRA;
        else if (expira)  nxt = FIM_TIMEOUT;
        else              nxt = ESPERA;
      end
      REGISTRA: nxt = COMPARA;
      COMPARA: begin
        if (!igual)    nxt = FIM_ERRO;
        else if (fimC) nxt = FIM_ACERTO;
        else           nxt = PROXIMO;
      end
      PROXIMO:  nxt = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
        nxt = iniciar ? PREPARA : state;
      default:  nxt = INICIAL;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they
  // line up with the state register and never see the inputs directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INICIAL;
      cnt       <= '0;
      zeraC     <= 1'b0;
      contaC    <= 1'b0;
      zeraR     <= 1'b0;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= nxt;
      // Counter only runs while staying in ESPERA; saturates instead
      // of wrapping when the timeout is disabled.
      if (state == ESPERA && nxt == ESPERA) begin
        if (cnt != '1) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      zeraC     <= 1'b0;
      contaC    <= 1'b0;
      zeraR     <= 1'b0;
      registraR <= 1'b0;
      pronto    <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
      case (nxt)
        PREPARA: begin
          zeraC <= 1'b1;
          zeraR <= 1'b1;
        end
        REGISTRA: registraR <= 1'b1;
        PROXIMO:  contaC    <= 1'b1;
        FIM_ACERTO: begin
          pronto  <= 1'b1;
          acertou <= 1'b1;
        end
        FIM_ERRO: begin
          pronto <= 1'b1;
          errou  <= 1'b1;
        end
        FIM_TIMEOUT: begin
          pronto  <= 1'b1;
          errou   <= 1'b1;
          timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign db_estado = state;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench: instance A (TIMEOUT=20) for win/mismatch rounds,
//   instance B (TIMEOUT=8) for timeout, counter restart and reset.
module tb_unidade_controle_jogo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int nc = 0;
  int nr = 0;

  logic rA = 1'b1, iA = 1'b0, jA = 1'b0, gA = 1'b0, fA = 1'b0;
  logic zcA, ccA, zrA, rrA, pA, acA, eA, tA;
  logic [3:0] stA;
  logic rB = 1'b1, iB = 1'b0, jB = 1'b0, gB = 1'b0, fB = 1'b0;
  logic zcB, ccB, zrB, rrB, pB, acB, eB, tB;
  logic [3:0] stB;

  wire [7:0] outA = {zcA, ccA, zrA, rrA, pA, acA, eA, tA};
  wire [7:0] outB = {zcB, ccB, zrB, rrB, pB, acB, eB, tB};

  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_PREP = 8'b1010_0000;
  localparam logic [7:0] O_REG  = 8'b0001_0000;
  localparam logic [7:0] O_PROX = 8'b0100_0000;
  localparam logic [7:0] O_WIN  = 8'b0000_1100;
  localparam logic [7:0] O_ERR  = 8'b0000_1010;
  localparam logic [7:0] O_TMO  = 8'b0000_1011;

  unidade_controle_jogo #(.TIMEOUT(20)) u_a (
    .clock(clk), .reset(rA), .iniciar(iA), .jogada_feita(jA),
    .igual(gA), .fimC(fA), .zeraC(zcA), .contaC(ccA), .zeraR(zrA),
    .registraR(rrA), .pronto(pA), .acertou(acA), .errou(eA),
    .timeout(tA), .db_estado(stA)
  );

  unidade_controle_jogo #(.TIMEOUT(8)) u_b (
    .clock(clk), .reset(rB), .iniciar(iB), .jogada_feita(jB),
    .igual(gB), .fimC(fB), .zeraC(zcB), .contaC(ccB), .zeraR(zrB),
    .registraR(rrB), .pronto(pB), .acertou(acB), .errou(eB),
    .timeout(tB), .db_estado(stB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    nc += int'(ccA);
    nr += int'(rrA);
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int st, input logic [7:0] o);
    chk({tag, " A state"}, int'(stA), st);
    chk({tag, " A outs"}, int'(outA), int'(o));
  endtask

  task automatic chk_b(input string tag, input int st, input logic [7:0] o);
    chk({tag, " B state"}, int'(stB), st);
    chk({tag, " B outs"}, int'(outB), int'(o));
  endtask

  task automatic idle_b(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk_b(tag, 2, O_NONE);
    end
  endtask

  initial begin
    // 1: reset with iniciar high, then release
    iA = 1'b1;
    tick();
    tick();
    chk_a("rst", 0, O_NONE);
    rA = 1'b0;
    tick();
    chk_a("prepara", 1, O_PREP);
    iA = 1'b0;
    tick();
    chk_a("espera", 2, O_NONE);

    // 2: sixteen matching plays
    nc = 0;
    nr = 0;
    for (int p = 1; p <= 16; p++) begin
      jA = 1'b1;
      gA = 1'b1;
      fA = (p == 16);
      tick();
      chk_a("win reg", 4, O_REG);
      jA = 1'b0;
      tick();
      chk_a("win cmp", 5, O_NONE);
      tick();
      if (p < 16) begin
        chk_a("win prox", 6, O_PROX);
        tick();
        chk_a("win esp", 2, O_NONE);
      end else begin
        chk_a("win fim", 10, O_WIN);
      end
    end
    fA = 1'b0;
    chk("win contaC", nc, 15);
    chk("win registraR", nr, 16);

    // 3: mismatch on third play
    iA = 1'b1;
    tick();
    chk_a("err prep", 1, O_PREP);
    iA = 1'b0;
    tick();
    nc = 0;
    for (int p = 1; p <= 3; p++) begin
      jA = 1'b1;
      gA = (p != 3);
      tick();
      jA = 1'b0;
      tick();
      chk_a("err cmp", 5, O_NONE);
      tick();
      if (p < 3) tick();
    end
    chk_a("err fim", 14, O_ERR);
    chk("err contaC", nc, 2);
    iA = 1'b1;
    tick();
    chk_a("err restart", 1, O_PREP);
    iA = 1'b0;
    tick();
    chk_a("err espera", 2, O_NONE);

    // 4: timeout with TIMEOUT=8
    tick();
    rB = 1'b0;
    iB = 1'b1;
    tick();
    chk_b("tmo prep", 1, O_PREP);
    iB = 1'b0;
    tick();
    chk_b("tmo esp1", 2, O_NONE);
    idle_b("tmo idle", 7);
    tick();
    chk_b("tmo fim", 13, O_TMO);

    // 4b: play on the 8th ESPERA cycle wins over expiry
    iB = 1'b1;
    tick();
    iB = 1'b0;
    tick();
    idle_b("late idle", 7);
    jB = 1'b1;
    gB = 1'b1;
    fB = 1'b0;
    tick();
    chk_b("late reg", 4, O_REG);
    jB = 1'b0;
    tick();
    tick();
    chk_b("late prox", 6, O_PROX);
    tick();
    chk_b("late esp", 2, O_NONE);

    // 5: play on 7th cycle, next ESPERA gets a full 8 cycles
    idle_b("rst idle", 6);
    jB = 1'b1;
    tick();
    chk_b("rs reg", 4, O_REG);
    jB = 1'b0;
    tick();
    tick();
    tick();
    chk_b("rs esp1", 2, O_NONE);
    idle_b("rs idle", 7);
    tick();
    chk_b("rs fim", 13, O_TMO);

    // 6: reset mid-round in COMPARA and in ESPERA
    iB = 1'b1;
    tick();
    iB = 1'b0;
    tick();
    jB = 1'b1;
    tick();
    jB = 1'b0;
    tick();
    chk_b("mid cmp", 5, O_NONE);
    rB = 1'b1;
    tick();
    chk_b("mid rst1", 0, O_NONE);
    rB = 1'b0;
    iB = 1'b1;
    tick();
    iB = 1'b0;
    tick();
    idle_b("mid idle", 5);
    rB = 1'b1;
    tick();
    chk_b("mid rst2", 0, O_NONE);
    rB = 1'b0;
    iB = 1'b1;
    tick();
    chk_b("mid prep", 1, O_PREP);
    iB = 1'b0;
    tick();
    idle_b("post idle", 7);
    tick();
    chk_b("post fim", 13, O_TMO);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
